pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register carrying a control/data payload between two CPU pipeline stages (e.g. EX→MEM, MEM→WB) with a valid/ready handshake. It adds what the fixed stage registers lack: asynchronous reset, stall back-pressure, synchronous flush, and masking of write-enable bits on bubbles. An optional two-entry skid buffer cuts the combinational ready path. A saturating stall counter supports performance debugging.

## Interface
- DATA_W, 48: payload width in bits; packs control fields, byte-write mask and data.
- WE_MASK, 48'h0: bits of the payload forced to 0 whenever the output is not valid; covers RegWr, DataWr and the wea field.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16: stall counter width.
- clk  in  1  stage clock; all state updates on the falling edge, as for the other stage registers.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream holds a valid payload.
- in_ready  out  1  stage accepts the payload on this edge.
- in_data  in  DATA_W  upstream payload.
- in_pc  in  32  PC of the upstream instruction.
- flush  in  1  discard all held entries; synchronous.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream consumes on this edge.
- out_data  out  DATA_W  payload, WE_MASK bits zeroed when out_valid=0.
- out_pc  out  32  PC of the held instruction.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

## Operation
- Accept: in_valid & in_ready at a falling edge. Consume: out_valid & out_ready at a falling edge.
- SKID=0: a single main register. in_ready = ~out_valid | out_ready. On accept, the main register loads in_data/in_pc and out_valid=1. Consume without accept sets out_valid=0.
- SKID=1: the main register M drives the outputs and the skid register S holds overflow. in_ready = ~S.valid (registered).
  - Accept while M is empty, or while M is consumed: data goes to M.
  - Accept while M is held (out_ready=0): data goes to S.
  - Consume while S is valid: S moves to M and S empties in the same edge.
- Transitions for states EMPTY, ONE (M valid) and FULL (M and S valid):
  - EMPTY: accept → ONE.
  - ONE: accept and consume → ONE (new data); consume only → EMPTY; accept only → FULL.
  - FULL: consume → ONE; no accept is possible in FULL.
- Flush has priority over accept and consume: next state EMPTY, both entries invalid, and a same-edge in_valid is dropped. Data registers may keep stale values, but out_data masked bits read 0.
- Masking: out_data = M.data & ~({DATA_W{~out_valid}} & WE_MASK). A bubble never writes the register file or memory.
- stall_cnt: increments at each falling edge where out_valid & ~out_ready; saturates at all-ones. It is cleared only by reset, not by flush.

## Timing
- Latency is one falling edge from accept to out_valid, with an empty stage. Throughput is one payload per cycle in steady state for both SKID modes.
- Reset (rst_n=0, asynchronous):
  - out_valid=0, M and S data and PC all 0, and stall_cnt=0.
  - in_ready=1 in both modes while reset is asserted and after it is released.
  - The state is EMPTY.
- Reset release is sampled on the falling edge; the first accept can occur on the first falling edge after release.
- Reset asserted mid-transfer drops all entries immediately, without waiting for an edge.
- SKID=1 has no combinational path from out_ready to in_ready. SKID=0 has one.
- Simultaneous flush and reset: reset dominates.

## Structure
- A shared package `pipe_pkg` holds the payload field offsets (RegDst, RegWr, Digit, DataWr, immres, cmp, Sign, wea) and the default WE_MASK constant built from them. All stage instances use these.
- One natural sub-module is `pipe_slot`: a valid, data and PC register with load and clear. It is instantiated once for M, and for S when SKID=1.
- stall_cnt logic stays in the top module.

## Test plan
- Reset: hold rst_n=0, drive in_valid=1 and in_data=48'hFFFF_FFFF_FFFF. Required: out_valid=0, out_data=0, stall_cnt=0, in_ready=1. After release, the first falling edge gives out_valid=1 and out_data=48'hFFFF_FFFF_FFFF.
- Streaming: send payloads 1..8 back-to-back with out_ready=1. Required: out_data is 1..8 on consecutive cycles, each one edge after its accept, with no bubbles, for SKID=0 and SKID=1.
- Stall in skid mode (SKID=1): accept A, hold out_ready=0, then offer B and C.
  - B is accepted into S, then in_ready=0 and C is held upstream.
  - Raising out_ready yields A, B, C in order.
  - stall_cnt equals the number of stalled edges, e.g. 3.
- Flush: with the stage FULL, assert flush together with in_valid=1 carrying payload D.
  - Required: out_valid=0 next edge and D is never output.
  - out_data WE_MASK bits read 0, e.g. a WE_MASK covering wea=4'hF yields wea=0.
- Bubble masking: set WE_MASK = RegWr|DataWr|wea and send a payload with all of them set, then idle. Required: after it is consumed, out_valid=0 and RegWr=DataWr=0, wea=4'h0.
- Counter saturation: with CNT_W=4, stall for 20 edges. Required: stall_cnt stops at 4'hF. A following flush leaves it at 4'hF.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared payload layout for the CPU stage registers (EX->MEM, MEM->WB).
// Every stage instance takes its field offsets and write-enable mask from here.
package pipe_pkg;

    localparam int PAYLOAD_W  = 48;

    localparam int REGDST_LSB = 0;
    localparam int REGDST_W   = 2;
    localparam int REGWR_BIT  = 2;
    localparam int DIGIT_LSB  = 3;
    localparam int DIGIT_W    = 2;
    localparam int DATAWR_BIT = 5;
    localparam int IMMRES_BIT = 6;
    localparam int CMP_BIT    = 7;
    localparam int SIGN_BIT   = 8;
    localparam int WEA_LSB    = 9;
    localparam int WEA_W      = 4;
    localparam int DATA_LSB   = 13;

    typedef struct packed {
        logic [PAYLOAD_W-DATA_LSB-1:0] data;
        logic [WEA_W-1:0]              wea;
        logic                          sign;
        logic                          cmp;
        logic                          immres;
        logic                          data_wr;
        logic [DIGIT_W-1:0]            digit;
        logic                          reg_wr;
        logic [REGDST_W-1:0]           reg_dst;
    } payload_t;

    function automatic logic [PAYLOAD_W-1:0] field_mask(input int lsb, input int width);
        logic [PAYLOAD_W-1:0] ones;
        ones = (PAYLOAD_W'(1) << width) - PAYLOAD_W'(1);
        return ones << lsb;
    endfunction

    // Everything that can cause a register-file or memory write.
    localparam logic [PAYLOAD_W-1:0] WE_MASK_DEFAULT =
        field_mask(REGWR_BIT, 1) | field_mask(DATAWR_BIT, 1) | field_mask(WEA_LSB, WEA_W);

endpackage

// File: rtl/pipe_slot.sv
// One holding register of a pipeline stage: valid flag, payload and PC.
// Clear wins over load; clear leaves the stale payload in place.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = PAYLOAD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    input  logic [31:0]       load_pc,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [31:0]       pc
);

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush, bubble write-masking,
// optional two-entry skid buffer and a saturating stall counter. Updates on falling edges.
//
//   state    | meaning
//   ---------+------------------------------------------
//   ST_EMPTY | no valid entry, outputs are a bubble
//   ST_ONE   | main register M valid, skid S empty
//   ST_FULL  | M and S valid, in_ready low (skid only)
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = PAYLOAD_W,
    parameter logic [DATA_W-1:0] WE_MASK = '0,
    parameter bit                SKID    = 1'b1,
    parameter int                CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [31:0]       in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       out_pc,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic              m_valid;
    logic              s_valid;
    logic [DATA_W-1:0] m_data;
    logic [DATA_W-1:0] s_data;
    logic [31:0]       m_pc;
    logic [31:0]       s_pc;
    logic              m_load;
    logic              m_clear;
    logic              m_from_s;
    logic              s_load;
    logic              s_clear;
    logic [DATA_W-1:0] m_load_data;
    logic [31:0]       m_load_pc;
    logic [1:0]        state;
    logic              accept;
    logic              consume;

    assign accept  = in_valid & in_ready;
    assign consume = m_valid & out_ready;

    // The slot valid bits are the state; decode them rather than keep a copy.
    assign state = s_valid ? ST_FULL : (m_valid ? ST_ONE : ST_EMPTY);

    always_comb begin
        m_load   = 1'b0;
        m_clear  = 1'b0;
        m_from_s = 1'b0;
        s_load   = 1'b0;
        s_clear  = 1'b0;
        if (flush) begin
            m_clear = 1'b1;
            s_clear = 1'b1;
        end else begin
            case (state)
                ST_EMPTY: m_load = accept;
                ST_ONE: begin
                    if (accept) begin
                        m_load = consume;
                        s_load = ~consume;
                    end else begin
                        m_clear = consume;
                    end
                end
                ST_FULL: begin
                    if (consume) begin
                        m_load   = 1'b1;
                        m_from_s = 1'b1;
                        s_clear  = 1'b1;
                    end
                end
                default: begin
                    m_clear = 1'b1;
                    s_clear = 1'b1;
                end
            endcase
        end
    end

    assign m_load_data = m_from_s ? s_data : in_data;
    assign m_load_pc   = m_from_s ? s_pc   : in_pc;

    pipe_slot #(.DATA_W(DATA_W)) u_main (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (m_load),
        .clear     (m_clear),
        .load_data (m_load_data),
        .load_pc   (m_load_pc),
        .valid     (m_valid),
        .data      (m_data),
        .pc        (m_pc)
    );

    if (SKID) begin : g_skid
        pipe_slot #(.DATA_W(DATA_W)) u_skid (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (s_load),
            .clear     (s_clear),
            .load_data (in_data),
            .load_pc   (in_pc),
            .valid     (s_valid),
            .data      (s_data),
            .pc        (s_pc)
        );
        // Registered ready: upstream timing no longer sees out_ready.
        assign in_ready = ~s_valid;
    end else begin : g_single
        assign s_valid  = 1'b0;
        assign s_data   = '0;
        assign s_pc     = '0;
        assign in_ready = ~m_valid | out_ready;
    end

    assign out_valid = m_valid;
    assign out_pc    = m_pc;
    assign out_data  = m_data & ~({DATA_W{~m_valid}} & WE_MASK);

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (m_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (CNT_W=4) and a single-register instance
// share one stimulus stream; a queue-level model is compared every falling edge.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam logic [47:0] MASK = WE_MASK_DEFAULT;

    logic        clk       = 1'b1;
    logic        rst_n     = 1'b1;
    logic        in_valid  = 1'b0;
    logic [47:0] in_data   = '0;
    logic [31:0] in_pc     = '0;
    logic        flush     = 1'b0;
    logic        out_ready = 1'b1;

    logic        sk_ready, sk_valid;
    logic [47:0] sk_data;
    logic [31:0] sk_pc;
    logic [3:0]  sk_stall;
    logic        rg_ready, rg_valid;
    logic [47:0] rg_data;
    logic [31:0] rg_pc;
    logic [15:0] rg_stall;

    int nchk = 0;
    int nerr = 0;

    pipe_stage_reg #(.DATA_W(48), .WE_MASK(MASK), .SKID(1'b1), .CNT_W(4)) u_skid (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sk_ready),
        .in_data(in_data), .in_pc(in_pc), .flush(flush), .out_valid(sk_valid),
        .out_ready(out_ready), .out_data(sk_data), .out_pc(sk_pc), .stall_cnt(sk_stall)
    );

    pipe_stage_reg #(.DATA_W(48), .WE_MASK(MASK), .SKID(1'b0), .CNT_W(16)) u_reg (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rg_ready),
        .in_data(in_data), .in_pc(in_pc), .flush(flush), .out_valid(rg_valid),
        .out_ready(out_ready), .out_data(rg_data), .out_pc(rg_pc), .stall_cnt(rg_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: each instance is a FIFO of capacity 2 (skid) or 1 (single register).
    logic [47:0] md[2][2];
    logic [31:0] mp[2][2];
    int          mn[2];
    logic [47:0] last_d[2];
    logic [31:0] last_p[2];
    int          mstall[2];
    bit          m_rdy, m_acc, m_con, e_v;
    logic [47:0] e_d;
    logic [31:0] e_p;

    function automatic int cmax(input int k);
        return (k == 0) ? 15 : 65535;
    endfunction

    function automatic bit model_ready(input int k, input int n, input logic ordy);
        return (k == 0) ? (n < 2) : (n == 0 || ordy);
    endfunction

    task automatic cmp_inst(input int k, input string pfx, input logic r, input logic v,
                            input logic [47:0] d, input logic [31:0] p, input int st);
        e_v = (mn[k] > 0);
        e_d = e_v ? md[k][0] : (last_d[k] & ~MASK);
        e_p = e_v ? mp[k][0] : last_p[k];
        chk({pfx, ".in_ready"},  64'(r), 64'(model_ready(k, mn[k], out_ready)));
        chk({pfx, ".out_valid"}, 64'(v), 64'(e_v));
        chk({pfx, ".out_data"},  64'(d), 64'(e_d));
        chk({pfx, ".out_pc"},    64'(p), 64'(e_p));
        chk({pfx, ".stall_cnt"}, 64'(st), 64'(mstall[k]));
    endtask

    always begin
        @(negedge clk or negedge rst_n);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                mn[k] = 0; last_d[k] = '0; last_p[k] = '0; mstall[k] = 0;
            end else begin
                m_rdy = model_ready(k, mn[k], out_ready);
                m_acc = in_valid && m_rdy;
                m_con = (mn[k] > 0) && out_ready;
                if (mn[k] > 0 && !out_ready && mstall[k] < cmax(k)) mstall[k]++;
                if (flush) begin
                    mn[k] = 0;
                end else begin
                    if (m_con) begin
                        md[k][0] = md[k][1]; mp[k][0] = mp[k][1]; mn[k]--;
                    end
                    if (m_acc) begin
                        md[k][mn[k]] = in_data; mp[k][mn[k]] = in_pc; mn[k]++;
                    end
                end
                if (mn[k] > 0) begin
                    last_d[k] = md[k][0]; last_p[k] = mp[k][0];
                end
            end
        end
        cmp_inst(0, "skid", sk_ready, sk_valid, sk_data, sk_pc, int'(sk_stall));
        cmp_inst(1, "reg",  rg_ready, rg_valid, rg_data, rg_pc, int'(rg_stall));
    end

    task automatic step(input logic v, input logic [47:0] d, input logic [31:0] p,
                        input logic f, input logic ordy);
        in_valid = v; in_data = d; in_pc = p; flush = f; out_ready = ordy;
        @(negedge clk);
        #2;
    endtask

    localparam logic [47:0] PA = 48'h0000_0000_A000;
    localparam logic [47:0] PB = 48'h0000_0000_B000;
    localparam logic [47:0] PC = 48'h0000_0000_C000;
    localparam logic [47:0] PD = 48'hDDDD_DDDD_FFFF;
    localparam logic [47:0] PE = 48'hAAAA_5555_FFFF;
    localparam logic [47:0] PF = 48'h5555_AAAA_FFFF;
    localparam logic [47:0] PP = 48'h1234_5678_9FFF;

    initial begin
        #1 rst_n = 1'b0;

        // Reset holds everything empty even with a valid offer.
        step(1'b1, 48'hFFFF_FFFF_FFFF, 32'd100, 1'b0, 1'b1);
        chk("rst.sk_valid", 64'(sk_valid), 64'h0);
        chk("rst.sk_data",  64'(sk_data),  64'h0);
        chk("rst.sk_stall", 64'(sk_stall), 64'h0);
        chk("rst.sk_ready", 64'(sk_ready), 64'h1);
        chk("rst.rg_ready", 64'(rg_ready), 64'h1);
        rst_n = 1'b1;
        step(1'b1, 48'hFFFF_FFFF_FFFF, 32'd100, 1'b0, 1'b1);
        chk("post_rst.sk_valid", 64'(sk_valid), 64'h1);
        chk("post_rst.sk_data",  64'(sk_data),  64'hFFFF_FFFF_FFFF);
        chk("post_rst.sk_pc",    64'(sk_pc),    64'd100);
        chk("post_rst.rg_data",  64'(rg_data),  64'hFFFF_FFFF_FFFF);
        step(1'b0, '0, '0, 1'b0, 1'b1);

        // Streaming, no bubbles.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 48'(i), 32'h1000 + 32'(4 * i), 1'b0, 1'b1);
            chk("stream.sk_data", 64'(sk_data), 64'(i));
            chk("stream.rg_data", 64'(rg_data), 64'(i));
            chk("stream.sk_valid", 64'(sk_valid), 64'h1);
        end
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("stream_end.sk_valid", 64'(sk_valid), 64'h0);

        // Skid stall: A in M, B into S, C held upstream.
        step(1'b1, PA, 32'hA, 1'b0, 1'b0);
        step(1'b1, PB, 32'hB, 1'b0, 1'b0);
        chk("stall.sk_ready", 64'(sk_ready), 64'h0);
        chk("stall.rg_ready", 64'(rg_ready), 64'h0);
        step(1'b1, PC, 32'hC, 1'b0, 1'b0);
        step(1'b1, PC, 32'hC, 1'b0, 1'b0);
        chk("stall.sk_data_a", 64'(sk_data),  64'(PA));
        chk("stall.sk_stall",  64'(sk_stall), 64'd3);
        step(1'b1, PC, 32'hC, 1'b0, 1'b1);
        chk("drain.sk_data_b", 64'(sk_data), 64'(PB));
        chk("drain.rg_data_c", 64'(rg_data), 64'(PC));
        step(1'b1, PC, 32'hC, 1'b0, 1'b1);
        chk("drain.sk_data_c", 64'(sk_data), 64'(PC));
        step(1'b0, '0, '0, 1'b0, 1'b1);

        // Flush while full; D offered on the same edge is dropped.
        step(1'b1, PE, 32'hE, 1'b0, 1'b0);
        step(1'b1, PF, 32'hF, 1'b0, 1'b0);
        chk("full.sk_ready", 64'(sk_ready), 64'h0);
        step(1'b1, PD, 32'hD, 1'b1, 1'b0);
        chk("flush.sk_valid", 64'(sk_valid), 64'h0);
        chk("flush.rg_valid", 64'(rg_valid), 64'h0);
        chk("flush.sk_data",  64'(sk_data),  64'hAAAA_5555_E1DB);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("flush_after.sk_valid", 64'(sk_valid), 64'h0);

        // Bubble masking of RegWr, DataWr and wea.
        step(1'b1, PP, 32'h50, 1'b0, 1'b1);
        chk("bubble.sk_data_live", 64'(sk_data), 64'(PP));
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("bubble.sk_valid", 64'(sk_valid), 64'h0);
        chk("bubble.sk_data",  64'(sk_data),  64'h1234_5678_81DB);
        chk("bubble.rg_data",  64'(rg_data),  64'h1234_5678_81DB);

        // Stall counter saturation, unaffected by flush.
        rst_n = 1'b0;
        step(1'b0, '0, '0, 1'b0, 1'b1);
        rst_n = 1'b1;
        chk("sat_rst.sk_stall", 64'(sk_stall), 64'h0);
        step(1'b1, 48'h77, 32'h77, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("sat.sk_stall", 64'(sk_stall), 64'hF);
        chk("sat.rg_stall", 64'(rg_stall), 64'd20);
        step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("sat_flush.sk_stall", 64'(sk_stall), 64'hF);
        chk("sat_flush.rg_stall", 64'(rg_stall), 64'd21);
        chk("sat_flush.sk_valid", 64'(sk_valid), 64'h0);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        chk("sat_idle.sk_stall", 64'(sk_stall), 64'hF);

        // Asynchronous reset between edges.
        step(1'b1, 48'h99, 32'h99, 1'b0, 1'b1);
        chk("pre_async.sk_valid", 64'(sk_valid), 64'h1);
        rst_n = 1'b0;
        #2;
        chk("async.sk_valid", 64'(sk_valid), 64'h0);
        chk("async.rg_valid", 64'(rg_valid), 64'h0);
        chk("async.sk_data",  64'(sk_data),  64'h0);
        chk("async.sk_stall", 64'(sk_stall), 64'h0);
        chk("async.sk_ready", 64'(sk_ready), 64'h1);
        chk("async.rg_ready", 64'(rg_ready), 64'h1);
        step(1'b0, '0, '0, 1'b0, 1'b1);
        rst_n = 1'b1;
        step(1'b1, 48'h42, 32'h42, 1'b0, 1'b1);
        chk("final.sk_data", 64'(sk_data), 64'h42);
        step(1'b0, '0, '0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
